// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//   - RV32I load/store width codes (store codes share encodings with
//     the corresponding signed load codes: SB=LB, SH=LH, SW=LW)
//   - byte-enable base patterns
//   - FSM state encoding
package mem_stage_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: purely combinational lane logic for the load/store unit.
//   funct3      in   width code (codes 3, 6, 7 behave as word)
//   addr_lo     in   ex_addr[1:0] (lane offset k)
//   store_data  in   rs2 value
//   rdata       in   read word from data memory
//   store_be    out  store byte enables, shifted to lane k
//   store_wdata out  store data replicated across lanes
//   load_data   out  extracted and sign/zero-extended load value
//   misaligned  out  access does not meet its natural alignment
module lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  store_be,
  output logic [31:0] store_wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    case (funct3)
      F3_LB, F3_LBU: misaligned = 1'b0;
      F3_LH, F3_LHU: misaligned = addr_lo[0];
      default:       misaligned = |addr_lo;
    endcase
  end

  // Replicating the data means the selected lane always carries the value,
  // whichever byte enables end up active.
  always_comb begin
    case (funct3)
      F3_LB, F3_LBU: begin
        store_be    = BE_BYTE << addr_lo;
        store_wdata = {4{store_data[7:0]}};
      end
      F3_LH, F3_LHU: begin
        store_be    = BE_HALF << addr_lo;
        store_wdata = {2{store_data[15:0]}};
      end
      default: begin
        store_be    = BE_WORD;
        store_wdata = store_data;
      end
    endcase
  end

  always_comb begin
    case (addr_lo)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    // Only even offsets reach this path for halfword loads.
    ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  load_data = {24'd0, ld_byte};
      F3_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  load_data = {16'd0, ld_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit of the 5-stage RV32I pipeline.
// Issues data-memory requests (req/gnt, then rvalid for loads), aligns store
// data, extends load data, stalls the pipeline while a transaction is
// outstanding and reports misaligned accesses and bus timeouts.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   ex_*                       EX/MEM register contents
//   dm_req/we/be/addr/wdata    data-memory request (combinational)
//   dm_gnt, dm_rvalid, dm_rdata data-memory responses
//   mem_*                      registered bundle for MEM/WB
//   stall                      freeze IF/ID/EX and EX/MEM
//   misalign_exc, bus_err      one-cycle exception pulses
//
// TIMEOUT_CYCLES must be below 2**CNT_W.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | no transaction outstanding; EX/MEM op handled directly
// S_REQ  | dm_req held with latched fields, waiting for dm_gnt
// S_RESP | load granted, waiting for dm_rvalid
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  input  logic [31:0] ex_rd_data,
  input  logic [4:0]  ex_write_addr,
  input  logic        ex_RegWrite,
  input  logic        ex_MemtoReg,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_rd_data,
  output logic [31:0] mem_load_data,
  output logic [4:0]  mem_write_addr,
  output logic        mem_RegWrite,
  output logic        mem_MemtoReg,
  output logic        stall,
  output logic        misalign_exc,
  output logic        bus_err
);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Request fields and pass-through data captured when a transaction starts.
  logic        lat_we;
  logic [3:0]  lat_be;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_addr_lo;
  logic [31:0] lat_rd_data;
  logic [4:0]  lat_write_addr;
  logic        lat_regwrite;
  logic        lat_memtoreg;

  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_store_be;
  logic [31:0] al_store_wdata;
  logic [31:0] al_load_data;
  logic        al_misaligned;

  logic is_mem_op;
  logic idle_op;
  logic idle_mem;
  logic idle_aligned;
  logic timeout;

  logic        out_valid;
  logic [31:0] out_rd;
  logic [31:0] out_ld;
  logic [4:0]  out_wa;
  logic        out_rw;
  logic        out_m2r;
  logic        out_mis;
  logic        out_berr;

  // In IDLE the aligner sees the live EX/MEM op; once a load is in flight it
  // sees the latched width/offset so the response can be extracted.
  assign al_funct3  = (state_q == S_IDLE) ? ex_funct3    : lat_funct3;
  assign al_addr_lo = (state_q == S_IDLE) ? ex_addr[1:0] : lat_addr_lo;

  lsu_align u_align (
    .funct3      (al_funct3),
    .addr_lo     (al_addr_lo),
    .store_data  (ex_store_data),
    .rdata       (dm_rdata),
    .store_be    (al_store_be),
    .store_wdata (al_store_wdata),
    .load_data   (al_load_data),
    .misaligned  (al_misaligned)
  );

  // reset gates the IDLE decode so dm_req and stall drop the moment reset
  // rises, even with a memory op sitting in EX/MEM.
  assign is_mem_op    = ex_mem_read | ex_mem_write;
  assign idle_op      = (state_q == S_IDLE) && ex_valid && !reset;
  assign idle_mem     = idle_op && is_mem_op;
  assign idle_aligned = idle_mem && !al_misaligned;
  assign timeout      = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_be    = 4'b0000;
    dm_addr  = 32'd0;
    dm_wdata = 32'd0;
    stall    = 1'b0;
    if (idle_aligned) begin
      dm_req   = 1'b1;
      dm_we    = ex_mem_write;
      dm_be    = ex_mem_write ? al_store_be : BE_WORD;
      dm_addr  = {ex_addr[31:2], 2'b00};
      dm_wdata = ex_mem_write ? al_store_wdata : 32'd0;
      // A store granted immediately completes this cycle without stalling.
      stall    = !(ex_mem_write && dm_gnt);
    end else if (state_q == S_REQ) begin
      dm_req   = 1'b1;
      dm_we    = lat_we;
      dm_be    = lat_be;
      dm_addr  = lat_addr;
      dm_wdata = lat_wdata;
      stall    = 1'b1;
    end else if (state_q == S_RESP) begin
      stall    = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_valid = 1'b0;
    out_rd    = lat_rd_data;
    out_ld    = 32'd0;
    out_wa    = lat_write_addr;
    out_rw    = lat_regwrite;
    out_m2r   = lat_memtoreg;
    out_mis   = 1'b0;
    out_berr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        out_rd  = ex_rd_data;
        out_wa  = ex_write_addr;
        out_rw  = ex_RegWrite;
        out_m2r = ex_MemtoReg;
        if (idle_op) begin
          if (!is_mem_op) begin
            out_valid = 1'b1;
          end else if (al_misaligned) begin
            out_valid = 1'b1;
            out_mis   = 1'b1;
            out_rw    = 1'b0;
          end else if (ex_mem_write) begin
            if (dm_gnt) begin
              out_valid = 1'b1;
            end else begin
              state_d = S_REQ;
              cnt_d   = '0;
            end
          end else begin
            state_d = dm_gnt ? S_RESP : S_REQ;
            cnt_d   = '0;
          end
        end
      end
      S_REQ: begin
        // gnt takes priority over a timeout landing on the same cycle;
        // rvalid is not looked at here.
        if (dm_gnt) begin
          cnt_d = '0;
          if (lat_we) begin
            out_valid = 1'b1;
            state_d   = S_IDLE;
          end else begin
            state_d = S_RESP;
          end
        end else if (timeout) begin
          out_valid = 1'b1;
          out_berr  = 1'b1;
          out_rw    = 1'b0;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (dm_rvalid) begin
          out_valid = 1'b1;
          out_ld    = al_load_data;
          state_d   = S_IDLE;
        end else if (timeout) begin
          out_valid = 1'b1;
          out_berr  = 1'b1;
          out_rw    = 1'b0;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The live request bus is captured directly, so REQ replays exactly what
  // was presented in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_we         <= 1'b0;
      lat_be         <= 4'b0000;
      lat_addr       <= 32'd0;
      lat_wdata      <= 32'd0;
      lat_funct3     <= 3'd0;
      lat_addr_lo    <= 2'd0;
      lat_rd_data    <= 32'd0;
      lat_write_addr <= 5'd0;
      lat_regwrite   <= 1'b0;
      lat_memtoreg   <= 1'b0;
    end else if (idle_aligned) begin
      lat_we         <= dm_we;
      lat_be         <= dm_be;
      lat_addr       <= dm_addr;
      lat_wdata      <= dm_wdata;
      lat_funct3     <= ex_funct3;
      lat_addr_lo    <= ex_addr[1:0];
      lat_rd_data    <= ex_rd_data;
      lat_write_addr <= ex_write_addr;
      lat_regwrite   <= ex_RegWrite;
      lat_memtoreg   <= ex_MemtoReg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid      <= 1'b0;
      misalign_exc   <= 1'b0;
      bus_err        <= 1'b0;
      mem_rd_data    <= 32'd0;
      mem_load_data  <= 32'd0;
      mem_write_addr <= 5'd0;
      mem_RegWrite   <= 1'b0;
      mem_MemtoReg   <= 1'b0;
    end else begin
      mem_valid    <= out_valid;
      misalign_exc <= out_mis;
      bus_err      <= out_berr;
      if (out_valid) begin
        mem_rd_data    <= out_rd;
        mem_load_data  <= out_ld;
        mem_write_addr <= out_wa;
        mem_RegWrite   <= out_rw;
        mem_MemtoReg   <= out_m2r;
      end
    end
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit of the 5-stage RV32I pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Issues data-memory requests over a req/gnt + rvalid handshake and generates byte enables and aligned store data.
- Extracts and sign/zero-extends load data, so MEM/WB receives a final value.
- Stalls the pipeline while a memory transaction is outstanding. Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: cycles waited for gnt or rvalid before aborting with bus_err.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_mem_read  in  1  load instruction
- ex_mem_write  in  1  store instruction
- ex_funct3  in  3  RV32I load/store width code
- ex_addr  in  32  effective address (ALU result)
- ex_store_data  in  32  rs2 value
- ex_rd_data  in  32  ALU result, passed through
- ex_write_addr  in  5  destination register
- ex_RegWrite  in  1  writeback enable
- ex_MemtoReg  in  1  1 = writeback selects load data
- dm_req  out  1  memory request
- dm_we  out  1  1 = write
- dm_be  out  4  byte enables, active-high
- dm_addr  out  32  word address, {ex_addr[31:2],2'b00}
- dm_wdata  out  32  lane-aligned store data
- dm_gnt  in  1  request accepted this cycle
- dm_rvalid  in  1  read data valid
- dm_rdata  in  32  read word
- mem_valid  out  1  output bundle valid for MEM/WB
- mem_rd_data  out  32  registered ex_rd_data
- mem_load_data  out  32  extended load result
- mem_write_addr  out  5  registered ex_write_addr
- mem_RegWrite  out  1  registered RegWrite, forced 0 on exception
- mem_MemtoReg  out  1  registered MemtoReg
- stall  out  1  freeze IF/ID/EX and EX/MEM
- misalign_exc  out  1  one-cycle pulse
- bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: state IDLE, counter 0. All outputs 0: mem_*, dm_*, stall, misalign_exc, bus_err.
- States: IDLE, REQ, RESP.
- IDLE, non-memory op (ex_valid, neither read nor write): register pass-through outputs next edge, mem_valid=1, mem_load_data=0. Latency 1, no stall.
- IDLE, aligned memory op:
  - dm_req, dm_we, dm_be, dm_addr and dm_wdata are driven combinationally in the same cycle.
  - stall=1 combinationally.
  - If dm_gnt is already 1: a store completes (outputs registered, mem_valid=1 next edge); a load goes to RESP.
  - Otherwise go to REQ. Request fields are latched so they stay stable while stalled.
- REQ: dm_req held with stable fields until dm_gnt. On gnt, a store completes and returns to IDLE; a load goes to RESP.
- RESP: wait for dm_rvalid, capture extended data, mem_valid=1 next edge, return to IDLE.
- stall=1 in REQ and RESP, and in IDLE whenever an aligned memory op is present and not completing this cycle.
- mem_valid=0 in every cycle without a completion.
- Alignment:
  - funct3 0/4 (B/BU): any address.
  - funct3 1/5 (H/HU): addr[0]=0.
  - funct3 2 (W): addr[1:0]=0.
  - funct3 3, 6, 7: treated as W.
- Misaligned op: no dm_req, no stall. misalign_exc pulses on the next edge together with mem_valid=1 and mem_RegWrite=0.
- Store lane shift k=ex_addr[1:0]:
  - SB: be=4'b0001<<k, wdata={4{data[7:0]}}.
  - SH: be=4'b0011<<k, wdata={2{data[15:0]}}.
  - SW: be=4'b1111, wdata=data.
- Load extract: byte = dm_rdata[8k+:8], half = dm_rdata[8k+:16].
  - LB: sign-extend byte to 32. LBU: zero-extend byte.
  - LH: sign-extend half. LHU: zero-extend half.
  - LW: dm_rdata unchanged.
- Loads: dm_be=4'b1111, dm_we=0.
- Timeout counter: cleared on entry to REQ or RESP, increments each waiting cycle. When it reaches TIMEOUT_CYCLES:
  - drop dm_req, return to IDLE;
  - bus_err pulse, mem_valid=1 with mem_RegWrite=0.
- Simultaneous events:
  - dm_rvalid while in REQ is ignored.
  - dm_gnt and timeout in the same cycle: gnt wins.
- Reset mid-transaction: immediate return to IDLE; dm_req deasserts asynchronously; the outstanding response is discarded.

Decomposition:
- Shared package: funct3 encodings (F3_LB..F3_LHU), lsu_state_e enum, byte-enable constants.
- One combinational sub-module, lsu_align, is natural: store lane alignment, load extraction and misalignment check, shared by the FSM datapath.

Test Plan:
- LB at addr 0x103, dm_rdata=0x80FF_1234, gnt/rvalid on first cycle -> dm_addr=0x100, dm_be=4'b1111; mem_load_data=0xFFFF_FF80, 2 stall cycles.
- SH at addr 0x202, data=0x0000_BEEF, gnt delayed 3 cycles -> dm_be=4'b1100, dm_wdata=0xBEEF_BEEF held stable through REQ; stall=1 for 4 cycles; mem_valid 1 cycle after gnt.
- LW at addr 0x006 -> no dm_req; misalign_exc=1 and mem_RegWrite=0 on next edge; stall=0 throughout.
- LHU at addr 0x40, rvalid never arrives, TIMEOUT_CYCLES=16 -> bus_err pulse after 16 RESP cycles, state IDLE, stall released.
- ALU op (ex_rd_data=0x1234, rd=5) back-to-back with loads -> pass-through after 1 cycle, mem_load_data=0, no stall.
- Assert reset while in RESP -> dm_req/stall/mem_valid=0 immediately; a later rvalid produces no mem_valid.
